gpr_file_mp: RTL and testbench
==============================

// Module: gpr_file_mp
// PURPOSE
//  Parametrised multi-port integer register file, next generation of the 1W2R LUTRAM GPR.
//  Adds N write ports (live-value-table banking), N read ports, write->read bypass,
//  hardware zero-clear after reset, and a per-register busy scoreboard for issue stall.
//  Sits between decode/issue (reads, busy) and writeback (writes) in the CPU core.
// PARAMETERS
//  XLEN      64  data width
//  NREG      32  register count, power of 2
//  AW        5   address width, clog2(NREG)
//  NRD       2   read ports, 1..4
//  NWR       2   write ports, 1..2
//  BYPASS    1   1 = same-cycle write data forwarded to matching read port
//  ZERO_REG  1   1 = register 0 reads 0, ignores writes, never busy
// PORTS
//  clk       in   1         clock
//  rst_n     in   1         async active-low reset
//  clk_en    in   1         global write/scoreboard enable
//  ready     out  1         0 during zero-clear, 1 when file usable
//  rs_addr   in   NRD*AW    read addresses, port i at [i*AW+:AW]
//  rs_data   out  NRD*XLEN  read data, combinational
//  rs_busy   out  NRD       busy bit of each addressed register
//  wb_we     in   NWR       write enables
//  wb_addr   in   NWR*AW    write addresses
//  wb_data   in   NWR*XLEN  write data
//  wb_clr    in   NWR       clear busy of wb_addr on this write
//  iss_set   in   1         mark iss_addr busy (new producer issued)
//  iss_addr  in   AW        destination being issued
//  flush     in   1         clear all busy bits
// BEHAVIOUR
//  Reset: rst_n low -> ready=0, FSM=CLEAR, clr_ptr=0, all busy=0, LVT=0; rs_data=0, rs_busy=0.
//  CLEAR: each cycle write 0 to clr_ptr in every bank, clr_ptr++; at clr_ptr==NREG-1 -> RUN next cycle.
//   ready rises exactly NREG cycles after rst_n deasserts; wb_*/iss_set/flush ignored while ready=0.
//  RUN: permanent until reset; reset mid-CLEAR restarts from clr_ptr=0.
//  Write: effective when ready & clk_en & wb_we[j] & !(ZERO_REG & wb_addr==0); registered on clk rise.
//   Same address on two ports same cycle: highest index port wins, lower write dropped.
//  Read: async; bank select from LVT[rs_addr]; ZERO_REG & addr==0 -> 0; ready=0 -> 0.
//   BYPASS=1: effective write to rs_addr this cycle -> rs_data=that wb_data (highest port wins).
//   BYPASS=0: read returns pre-write value; new value visible cycle after.
//  Scoreboard (one bit/reg, flops): next state per reg r:
//   flush -> 0 (overrides everything); else iss_set&iss_addr==r -> 1 (set beats same-cycle clr);
//   else effective write with wb_clr to r -> 0; else hold. Gated by ready & clk_en except flush (ready only).
//   rs_busy reflects registered state (no bypass of same-cycle set/clr). Reg 0 never busy when ZERO_REG.
//  Widths: no arithmetic; all addresses compared full AW bits.
// STRUCTURE
//  Shared package gpr_pkg: XLEN/NREG/AW defaults, FSM state enc (CLEAR=1'b0, RUN=1'b1).
//  Sub-module gpr_lutram_bank: 1W1R, async read, no reset, XLEN x NREG (vendor DRAM or inferred).
//  Instantiate NWR*NRD banks: bank[j][i] written by port j (or clear), read by port i.
//  LVT: NREG x clog2(NWR) flops, written with winning port index; reset to 0.
//  Write mux into banks selects clear path (data 0, addr clr_ptr, we=1) when ready=0.
// TESTING
//  1 Reset release -> ready=0 for 32 cycles, 1 on 33rd; read all 32 addrs -> all 0x0.
//  2 wb0 writes x5=0xDEAD, wb1 writes x6=0xBEEF same cycle -> next cycle rs0(x5)=0xDEAD, rs1(x6)=0xBEEF.
//  3 Both ports write x7 (0x1 port0, 0x2 port1) -> x7 reads 0x2; BYPASS=1 same cycle rs0(x7)=0x2.
//  4 Write x0=0xFFFF, iss_set x0 -> rs_data(x0)=0, rs_busy=0.
//  5 iss_set x9 -> busy 1 next cycle; wb x9 wb_clr with iss_set x9 same cycle -> stays 1;
//    later wb_clr alone -> 0; iss_set x3 + flush same cycle -> x3 busy 0.
//  6 Assert rst_n low mid-CLEAR at cycle 10 -> ready stays 0, clear restarts, 32 full cycles again.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared definitions for the multi-port GPR file: default geometry, FSM
// state encoding and a helper that sizes the live-value-table entries.
package gpr_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } gpr_state_e;

    // Width of one LVT entry; kept at least one bit so a single write port
    // still yields a legal vector.
    function automatic int lvt_width(input int nwr);
        if (nwr > 1) begin
            return $clog2(nwr);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/gpr_file_mp_bank.sv
// One write / one read storage bank with asynchronous read and no reset.
// Maps onto distributed RAM; contents are initialised by the zero-clear pass.
module gpr_lutram_bank
    import gpr_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem_r [NREG];

    // Synchronous write port, no reset so the array stays RAM-mappable
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port integer register file. NWR write ports are banked with a
// live-value table (LVT) recording which port last wrote each register;
// each read port has its own copy of every write bank. A zero-clear pass
// after reset initialises all banks, and a busy scoreboard tracks
// outstanding producers for issue stall.
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int AW       = AW_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      wb_we,
    input  logic [NWR*AW-1:0]   wb_addr,
    input  logic [NWR*XLEN-1:0] wb_data,
    input  logic [NWR-1:0]      wb_clr,
    input  logic                iss_set,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
);

    localparam int          LVW      = lvt_width(NWR);
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_LAST = AW'(NREG - 1);

    gpr_state_e      state_r, state_nxt_s;
    logic [AW-1:0]   clr_ptr_r, clr_ptr_nxt_s;
    logic            ready_s;

    logic [AW-1:0]   wr_addr_s [NWR];
    logic [XLEN-1:0] wr_data_s [NWR];
    logic [NWR-1:0]  eff_we_s;
    logic [NWR-1:0]  win_we_s;

    logic [LVW-1:0]  lvt_r [NREG];
    logic [NREG-1:0] busy_r, busy_nxt_s;

    logic [XLEN-1:0] bank_rdata_s [NWR][NRD];

    assign ready_s = (state_r == ST_RUN);
    assign ready   = ready_s;

    // Clear/run state register and clear pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= ADDR_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
        end
    end

    // Zero-clear sequencing: one register per cycle, then run until reset
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        case (state_r)
            ST_CLEAR: begin
                clr_ptr_nxt_s = clr_ptr_r + ADDR_ONE;
                if (clr_ptr_r == ADDR_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_ptr_nxt_s = ADDR_ZERO;
            end
        endcase
    end

    // Per write port: unpack, qualify and drive its row of banks
    for (genvar j = 0; j < NWR; j++) begin : g_wr
        logic            bank_we_s;
        logic [AW-1:0]   bank_waddr_s;
        logic [XLEN-1:0] bank_wdata_s;

        assign wr_addr_s[j] = wb_addr[j*AW +: AW];
        assign wr_data_s[j] = wb_data[j*XLEN +: XLEN];
        assign eff_we_s[j]  = ready_s & clk_en & wb_we[j]
                              & ~(ZERO_REG & (wr_addr_s[j] == ADDR_ZERO));

        // While clearing, every bank takes zero at the clear pointer
        assign bank_we_s    = ready_s ? win_we_s[j]  : 1'b1;
        assign bank_waddr_s = ready_s ? wr_addr_s[j] : clr_ptr_r;
        assign bank_wdata_s = ready_s ? wr_data_s[j] : {XLEN{1'b0}};

        for (genvar i = 0; i < NRD; i++) begin : g_bank
            gpr_lutram_bank #(
                .XLEN (XLEN),
                .NREG (NREG),
                .AW   (AW)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we_s),
                .waddr (bank_waddr_s),
                .wdata (bank_wdata_s),
                .raddr (rs_addr[i*AW +: AW]),
                .rdata (bank_rdata_s[j][i])
            );
        end
    end

    // Same-address collision: a higher-numbered port drops the lower write
    always_comb begin
        win_we_s = eff_we_s;
        for (int j = 0; j < NWR; j++) begin
            for (int k = j + 1; k < NWR; k++) begin
                if (eff_we_s[k] && (wr_addr_s[k] == wr_addr_s[j])) begin
                    win_we_s[j] = 1'b0;
                end else begin
                    win_we_s[j] = win_we_s[j];
                end
            end
        end
    end

    // LVT records which bank holds the live value of each register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                lvt_r[r] <= {LVW{1'b0}};
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (win_we_s[j]) begin
                    lvt_r[wr_addr_s[j]] <= LVW'(j);
                end
            end
        end
    end

    // Scoreboard next state: flush, then issue set, then writeback clear
    always_comb begin
        busy_nxt_s = busy_r;
        if (ready_s && flush) begin
            busy_nxt_s = {NREG{1'b0}};
        end else if (ready_s && clk_en) begin
            for (int r = 0; r < NREG; r++) begin
                for (int j = 0; j < NWR; j++) begin
                    if (eff_we_s[j] && wb_clr[j] && (wr_addr_s[j] == AW'(r))) begin
                        busy_nxt_s[r] = 1'b0;
                    end else begin
                        busy_nxt_s[r] = busy_nxt_s[r];
                    end
                end
                if (iss_set && (iss_addr == AW'(r))) begin
                    busy_nxt_s[r] = 1'b1;
                end else begin
                    busy_nxt_s[r] = busy_nxt_s[r];
                end
            end
            if (ZERO_REG) begin
                busy_nxt_s[0] = 1'b0;
            end else begin
                busy_nxt_s[0] = busy_nxt_s[0];
            end
        end else begin
            busy_nxt_s = busy_r;
        end
    end

    // Busy scoreboard flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Per read port: LVT bank select with zero-register and bypass override
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] data_s;

        assign addr_s = rs_addr[i*AW +: AW];

        // Priority: not ready, register zero, same-cycle write, stored value
        always_comb begin
            data_s = bank_rdata_s[lvt_r[addr_s]][i];
            if (!ready_s) begin
                data_s = {XLEN{1'b0}};
            end else if (ZERO_REG && (addr_s == ADDR_ZERO)) begin
                data_s = {XLEN{1'b0}};
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (BYPASS && eff_we_s[j] && (wr_addr_s[j] == addr_s)) begin
                        data_s = wr_data_s[j];
                    end else begin
                        data_s = data_s;
                    end
                end
            end
        end

        assign rs_data[i*XLEN +: XLEN] = data_s;
        assign rs_busy[i]              = busy_r[addr_s];
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench for gpr_file_mp with default parameters (64b, 32 regs,
// 2R/2W, bypass on, register zero hard-wired).
module tb_gpr_file_mp;

    logic         clk;
    logic         rst_n;
    logic         clk_en;
    logic         ready;
    logic [9:0]   rs_addr;
    logic [127:0] rs_data;
    logic [1:0]   rs_busy;
    logic [1:0]   wb_we;
    logic [9:0]   wb_addr;
    logic [127:0] wb_data;
    logic [1:0]   wb_clr;
    logic         iss_set;
    logic [4:0]   iss_addr;
    logic         flush;

    int checks_cnt = 0;
    int errors_cnt = 0;

    gpr_file_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .ready    (ready),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_clr   (wb_clr),
        .iss_set  (iss_set),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
    endtask

    task automatic drive_wb(input logic [1:0] we, input logic [4:0] a0, input logic [63:0] d0,
                            input logic [4:0] a1, input logic [63:0] d1, input logic [1:0] clr);
        wb_we   = we;
        wb_addr = {a1, a0};
        wb_data = {d1, d0};
        wb_clr  = clr;
    endtask

    // One clock edge, then drop all one-shot controls
    task automatic step();
        @(posedge clk);
        #1;
        wb_we   = 2'b00;
        wb_clr  = 2'b00;
        iss_set = 1'b0;
        flush   = 1'b0;
    endtask

    // Release reset on a falling edge and count rising edges until ready
    task automatic release_and_wait(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val(tag, 64'(n), 64'd32);
    endtask

    initial begin
        rst_n    = 1'b0;
        clk_en   = 1'b1;
        rs_addr  = 10'd0;
        wb_we    = 2'b00;
        wb_addr  = 10'd0;
        wb_data  = 128'd0;
        wb_clr   = 2'b00;
        iss_set  = 1'b0;
        iss_addr = 5'd0;
        flush    = 1'b0;

        // 1: reset state, clear latency, all registers read zero
        repeat (3) @(posedge clk);
        #1;
        set_rd(5'd5, 5'd6);
        #1;
        check_val("rst_ready", 64'(ready), 64'd0);
        check_val("rst_rs_data", rs_data[63:0] | rs_data[127:64], 64'd0);
        check_val("rst_rs_busy", 64'(rs_busy), 64'd0);
        release_and_wait("clear_latency");
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            #1;
            check_val($sformatf("clr_rd0_x%0d", a), rs_data[63:0], 64'd0);
            check_val($sformatf("clr_rd1_x%0d", 31 - a), rs_data[127:64], 64'd0);
        end

        // 2: independent writes on both ports
        drive_wb(2'b11, 5'd5, 64'hDEAD, 5'd6, 64'hBEEF, 2'b00);
        set_rd(5'd5, 5'd6);
        step();
        check_val("wr_x5", rs_data[63:0], 64'hDEAD);
        check_val("wr_x6", rs_data[127:64], 64'hBEEF);

        // LVT follows the last writing port
        drive_wb(2'b10, 5'd0, 64'd0, 5'd5, 64'h1111, 2'b00);
        step();
        check_val("lvt_p1_x5", rs_data[63:0], 64'h1111);
        check_val("lvt_hold_x6", rs_data[127:64], 64'hBEEF);
        drive_wb(2'b01, 5'd5, 64'h2222, 5'd0, 64'd0, 2'b00);
        step();
        check_val("lvt_p0_x5", rs_data[63:0], 64'h2222);

        // clk_en low: write ignored, not bypassed either
        clk_en = 1'b0;
        drive_wb(2'b01, 5'd5, 64'h5555, 5'd0, 64'd0, 2'b00);
        #1;
        check_val("noen_byp_x5", rs_data[63:0], 64'h2222);
        step();
        check_val("noen_x5", rs_data[63:0], 64'h2222);
        clk_en = 1'b1;

        // 3: same-address collision, higher port wins, bypass too
        drive_wb(2'b11, 5'd7, 64'h1, 5'd7, 64'h2, 2'b00);
        set_rd(5'd7, 5'd7);
        #1;
        check_val("coll_byp_x7", rs_data[63:0], 64'h2);
        step();
        check_val("coll_rd0_x7", rs_data[63:0], 64'h2);
        check_val("coll_rd1_x7", rs_data[127:64], 64'h2);

        // 4: register zero ignores writes and issue
        drive_wb(2'b01, 5'd0, 64'hFFFF, 5'd0, 64'd0, 2'b00);
        iss_set  = 1'b1;
        iss_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        #1;
        check_val("x0_byp", rs_data[63:0], 64'd0);
        step();
        check_val("x0_data", rs_data[63:0], 64'd0);
        check_val("x0_busy", 64'(rs_busy[0]), 64'd0);

        // 5: scoreboard
        iss_set  = 1'b1;
        iss_addr = 5'd9;
        set_rd(5'd9, 5'd9);
        #1;
        check_val("busy_no_byp", 64'(rs_busy[0]), 64'd0);
        step();
        check_val("busy_set_x9", 64'(rs_busy[0]), 64'd1);
        drive_wb(2'b01, 5'd9, 64'h99, 5'd0, 64'd0, 2'b01);
        iss_set  = 1'b1;
        iss_addr = 5'd9;
        step();
        check_val("busy_set_beats_clr", 64'(rs_busy[0]), 64'd1);
        check_val("busy_wr_x9", rs_data[63:0], 64'h99);
        drive_wb(2'b10, 5'd0, 64'd0, 5'd9, 64'h9A, 2'b10);
        step();
        check_val("busy_clr_x9", 64'(rs_busy[0]), 64'd0);
        iss_set  = 1'b1;
        iss_addr = 5'd4;
        step();
        set_rd(5'd3, 5'd4);
        #1;
        check_val("busy_set_x4", 64'(rs_busy[1]), 64'd1);
        iss_set  = 1'b1;
        iss_addr = 5'd3;
        flush    = 1'b1;
        step();
        check_val("flush_x3", 64'(rs_busy[0]), 64'd0);
        check_val("flush_x4", 64'(rs_busy[1]), 64'd0);

        // 6: reset during clear restarts the whole pass
        iss_set  = 1'b1;
        iss_addr = 5'd9;
        step();
        rst_n = 1'b0;
        #3;
        check_val("rst2_ready", 64'(ready), 64'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_val("midclr_ready", 64'(ready), 64'd0);
        rst_n = 1'b0;
        #3;
        check_val("midclr_rst_ready", 64'(ready), 64'd0);
        release_and_wait("reclear_latency");
        set_rd(5'd5, 5'd9);
        #1;
        check_val("reclr_x5", rs_data[63:0], 64'd0);
        check_val("reclr_x9", rs_data[127:64], 64'd0);
        check_val("reclr_busy_x9", 64'(rs_busy[1]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
